// File: rtl/ssd_pkg.sv
// Shared types and glyph table for the seven-segment scan driver.
// All segment patterns are active-low {g,f,e,d,c,b,a}.
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t G0 = 7'h40;
    localparam seg_t G1 = 7'h79;
    localparam seg_t G2 = 7'h24;
    localparam seg_t G3 = 7'h30;
    localparam seg_t G4 = 7'h19;
    localparam seg_t G5 = 7'h12;
    localparam seg_t G6 = 7'h02;
    localparam seg_t G7 = 7'h78;
    localparam seg_t G8 = 7'h00;
    localparam seg_t G9 = 7'h10;
    localparam seg_t GA = 7'h08;
    localparam seg_t GB = 7'h03;
    localparam seg_t GC = 7'h46;
    localparam seg_t GD = 7'h21;
    localparam seg_t GE = 7'h06;
    localparam seg_t GF = 7'h0E;

    // Legacy decoder showed '0' for anything above 9; hex=0 keeps that behaviour.
    function automatic seg_t glyph(input logic [3:0] v, input bit hex);
        case (v)
            4'h0: return G0;
            4'h1: return G1;
            4'h2: return G2;
            4'h3: return G3;
            4'h4: return G4;
            4'h5: return G5;
            4'h6: return G6;
            4'h7: return G7;
            4'h8: return G8;
            4'h9: return G9;
            4'hA: return hex ? GA : G0;
            4'hB: return hex ? GB : G0;
            4'hC: return hex ? GC : G0;
            4'hD: return hex ? GD : G0;
            4'hE: return hex ? GE : G0;
            default: return hex ? GF : G0;
        endcase
    endfunction

endpackage

// File: rtl/ssd_glyph_rom.sv
// Combinational nibble-to-segment lookup, shared by all digits of the scan.
module ssd_glyph_rom
    import ssd_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = glyph(nib, HEX_MODE != 0);

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous
// double buffering, leading-zero suppression and an anti-ghost blank gap.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 4_000,
    parameter int BLANK_CYCLES = 16,
    parameter int HEX_MODE     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_en,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic                      lz_suppress,
    input  logic                      load,
    output seg_t                      seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          slot_end, last_dig, boundary;

    logic [NUM_DIGITS-1:0][3:0] pend_dig, act_dig;
    logic [NUM_DIGITS-1:0]      pend_dp, pend_blank, act_dp, act_blank;
    logic                       pend_valid;

    assign slot_end = (cnt == CNT_LAST);
    assign last_dig = (idx == IDX_LAST);
    assign boundary = slot_end && last_dig;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= last_dig ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load on the boundary bypasses pending so the newest data wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            act_dig    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (load) begin
                act_dig   <= digits;
                act_dp    <= dp_en;
                act_blank <= blank;
            end else if (pend_valid) begin
                act_dig   <= pend_dig;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
        end else if (load) begin
            pend_dig   <= digits;
            pend_dp    <= dp_en;
            pend_blank <= blank;
            pend_valid <= 1'b1;
        end
    end

    // lz_dark[i]: every active nibble from i up to the MSD is zero.
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  zero_above;

    always_comb begin
        lz_dark    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (act_dig[i] == 4'h0);
            lz_dark[i] = lz_suppress && zero_above;
        end
    end

    logic [3:0] cur_nib;
    seg_t       cur_glyph;
    logic       cur_dark, lit;

    assign cur_nib  = act_dig[idx];
    assign cur_dark = act_blank[idx] || lz_dark[idx];
    assign lit      = (cnt >= BLANK_END);

    ssd_glyph_rom #(.HEX_MODE(HEX_MODE)) u_rom (
        .nib (cur_nib),
        .seg (cur_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (!lit) begin
                seg <= SEG_BLANK;
                dp  <= 1'b1;
                an  <= '1;
            end else begin
                seg <= cur_dark ? SEG_BLANK : cur_glyph;
                dp  <= cur_dark || !act_dp[idx];
                an  <= ~(NUM_DIGITS'(1) << idx);
            end
        end
    end

endmodule
